// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider (32 steps), signed/unsigned,
// registered {remainder, quotient} result with stall/annul handshake.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_signed,
  input  logic [DATA_W-1:0]     div_op1,
  input  logic [DATA_W-1:0]     div_op2,
  input  logic                  div_start,
  input  logic                  div_annul,
  output logic [2*DATA_W-1:0]   div_result,
  output logic                  div_ready
);

  localparam int              CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t                r_state;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;
  logic [DATA_W-1:0]     r_div;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic                  w_accept;
  logic                  w_op1_neg;
  logic                  w_op2_neg;
  logic [DATA_W-1:0]     w_op1_mag;
  logic [DATA_W-1:0]     w_op2_mag;
  logic [DATA_W:0]       w_up;
  logic                  w_ge;
  logic [DATA_W-1:0]     w_diff;
  logic [DATA_W-1:0]     w_q_fix;
  logic [DATA_W-1:0]     w_r_fix;

  assign w_accept  = div_start & ~div_annul;
  assign w_op1_neg = div_signed & div_op1[DATA_W-1];
  assign w_op2_neg = div_signed & div_op2[DATA_W-1];
  assign w_op1_mag = w_op1_neg ? -div_op1 : div_op1;
  assign w_op2_mag = w_op2_neg ? -div_op2 : div_op2;

  // The partial remainder is always below the divisor, so the shifted
  // remainder fits in DATA_W+1 bits and the difference fits in DATA_W bits.
  assign w_up   = {r_rem, r_quo[DATA_W-1]};
  assign w_ge   = (w_up >= {1'b0, r_div});
  assign w_diff = w_up[DATA_W-1:0] - r_div;

  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  assign div_result = r_result;
  assign div_ready  = r_ready;

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          if (w_accept) begin
            if (div_op2 == '0) begin
              r_state <= S_BYZERO;
            end else begin
              r_quo   <= w_op1_mag;
              r_div   <= w_op2_mag;
              r_rem   <= '0;
              r_cnt   <= '0;
              r_neg_q <= w_op1_neg ^ w_op2_neg;
              r_neg_r <= w_op1_neg;
              r_state <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          r_result <= '0;
          if (div_annul) begin
            r_ready <= 1'b0;
            r_state <= S_FREE;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_END;
          end
        end
        S_ON: begin
          if (div_annul) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_FREE;
          end else if (r_cnt == CNT_LAST) begin
            r_result <= {w_r_fix, w_q_fix};
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end else begin
            if (w_ge) begin
              r_rem <= w_diff;
              r_quo <= {r_quo[DATA_W-2:0], 1'b1};
            end else begin
              r_rem <= w_up[DATA_W-1:0];
              r_quo <= {r_quo[DATA_W-2:0], 1'b0};
            end
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_END: begin
          if (!w_accept) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_FREE;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          r_state  <= S_FREE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed corner cases plus randomized divides checked
// against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_start;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;

  int unsigned n_checks;
  int unsigned n_errors;

  div_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_signed (div_signed),
    .div_op1    (div_op1),
    .div_op2    (div_op2),
    .div_start  (div_start),
    .div_annul  (div_annul),
    .div_result (div_result),
    .div_ready  (div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division in 64-bit arithmetic; remainder takes the
  // dividend's sign; divide by zero yields zero.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called #1 after the accepting edge; counts edges until ready.
  task automatic wait_done(input string tag, input logic [63:0] exp, input int lat);
    int n;
    n = 0;
    while (!div_ready && n < lat + 8) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, div_result, exp);
  endtask

  task automatic release_unit(input string tag, input logic by_annul);
    @(negedge clk);
    if (by_annul) div_annul = 1'b1;
    else          div_start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_rel_rdy"}, 64'(div_ready), 64'd0);
    check({tag, "_rel_res"}, div_result, 64'd0);
    @(negedge clk);
    div_annul = 1'b0;
    div_start = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int hold, input logic by_annul);
    @(negedge clk);
    div_signed = s; div_op1 = a; div_op2 = b;
    div_start = 1'b1; div_annul = 1'b0;
    @(posedge clk); #1;
    // operands must be ignored once accepted
    div_op1 = $urandom; div_op2 = $urandom; div_signed = 1'($urandom);
    wait_done(tag, exp, (b == 32'd0) ? 1 : 33);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_rdy"}, 64'(div_ready), 64'd1);
      check({tag, "_hold_res"}, div_result, exp);
    end
    release_unit(tag, by_annul);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; div_signed = 1'b0; div_op1 = '0; div_op2 = '0;
    div_start = 1'b0; div_annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", 64'(div_ready), 64'd0);
    check("reset_res", div_result, 64'd0);

    // first accept on the first edge after reset drops
    @(negedge clk);
    rst = 1'b0; div_op1 = 32'd50; div_op2 = 32'd6; div_start = 1'b1;
    @(posedge clk); #1;
    wait_done("first", 64'h00000002_00000008, 33);
    release_unit("first", 1'b0);

    run_div("u100_7",   1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 3, 1'b0);
    run_div("s_m7_2",   1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1, 1'b0);
    run_div("s_7_m2",   1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1, 1'b1);
    run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1, 1'b0);
    run_div("byzero",   1'b0, 32'd1234,     32'd0,        64'd0,                 2, 1'b0);

    // annul mid-divide, then accept 9/3 on the next edge
    @(negedge clk);
    div_signed = 1'b0; div_op1 = 32'hFFFFFFFF; div_op2 = 32'd1; div_start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      check("annul_pre_rdy", 64'(div_ready), 64'd0);
    end
    @(negedge clk); div_annul = 1'b1;
    @(posedge clk); #1;
    check("annul_rdy", 64'(div_ready), 64'd0);
    check("annul_res", div_result, 64'd0);
    @(negedge clk); div_annul = 1'b0; div_op1 = 32'd9; div_op2 = 32'd3;
    @(posedge clk); #1;
    wait_done("after_annul", 64'h00000000_00000003, 33);
    release_unit("after_annul", 1'b0);

    // annul while in BYZERO, then start+annul held in FREE must not accept
    @(negedge clk);
    div_op1 = 32'd5; div_op2 = 32'd0; div_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); div_annul = 1'b1;
    @(posedge clk); #1;
    check("bz_annul_rdy", 64'(div_ready), 64'd0);
    @(posedge clk); #1;
    check("free_annul_rdy", 64'(div_ready), 64'd0);
    @(negedge clk); div_annul = 1'b0; div_op1 = 32'd77; div_op2 = 32'd10;
    @(posedge clk); #1;
    wait_done("post_bz", 64'h00000007_00000007, 33);
    release_unit("post_bz", 1'b0);

    // start dropped during ON: completes, then leaves END next edge
    @(negedge clk);
    div_signed = 1'b1; div_op1 = 32'hFFFFFF9C; div_op2 = 32'd7; div_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); div_start = 1'b0;
    @(posedge clk); #1;
    wait_done("nostart", 64'hFFFFFFFE_FFFFFFF2, 32);
    @(posedge clk); #1;
    check("nostart_free_rdy", 64'(div_ready), 64'd0);
    check("nostart_free_res", div_result, 64'd0);

    // reset at step 20, start held: full latency after reset drops
    @(negedge clk);
    div_signed = 1'b0; div_op1 = 32'd1000; div_op2 = 32'd3; div_start = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1; div_annul = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_rdy", 64'(div_ready), 64'd0);
    check("rst_mid_res", div_result, 64'd0);
    @(negedge clk); rst = 1'b0; div_annul = 1'b0; div_op1 = 32'd1001;
    @(posedge clk); #1;
    wait_done("rst_restart", 64'h00000002_0000014D, 33);
    release_unit("rst_restart", 1'b0);

    // randomized
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = a;
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_div("rand", s, a, b, model(s, a, b), $urandom_range(0, 2), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
